// File: rtl/signed_alu_top.sv
// signed_alu_top: registered signed ALU execute stage (arith, logic, compare, shift units)
// Ports:
//   clk        - clock, all outputs update on the rising edge
//   rst        - asynchronous reset, active-low; clears every output while low
//   A, B       - signed operands, OP_DATA_WIDTH bits
//   ALU_FUN    - [3:2] unit select, [1:0] operation select
//   Arith_OUT  - signed arithmetic result, ARITH_OUT_WIDTH bits
//   Logic_Out  - bitwise logic result
//   CMP_Out    - compare code (0/1/2/3)
//   Shift_Out  - logical shift result
//   *_Flag     - one-hot flag marking the unit selected on the last edge
// Configuration:
//   ALU_DIV_EN - when defined, op 0011 is signed division (truncating toward zero);
//                when undefined no divider is built and op 0011 yields 0.
module signed_alu_top #(
    parameter int OP_DATA_WIDTH   = 16,
    parameter int ARITH_OUT_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic signed [OP_DATA_WIDTH-1:0]   A,
    input  logic signed [OP_DATA_WIDTH-1:0]   B,
    input  logic        [3:0]                 ALU_FUN,
    output logic signed [ARITH_OUT_WIDTH-1:0] Arith_OUT,
    output logic        [OP_DATA_WIDTH-1:0]   Logic_Out,
    output logic        [OP_DATA_WIDTH-1:0]   CMP_Out,
    output logic        [OP_DATA_WIDTH-1:0]   Shift_Out,
    output logic                              Arith_Flag,
    output logic                              Logic_Flag,
    output logic                              CMP_Flag,
    output logic                              Shift_Flag
);
    localparam int W  = OP_DATA_WIDTH;
    localparam int AW = ARITH_OUT_WIDTH;

    logic signed [AW-1:0] a_x, b_x, div_q, arith_d;
    logic        [W-1:0]  logic_d, cmp_d, shift_d;
    logic        [1:0]    op, unit;

    assign op   = ALU_FUN[1:0];
    assign unit = ALU_FUN[3:2];
    // Widening before any arithmetic keeps the full product and the
    // most-negative / -1 quotient representable.
    assign a_x  = {{(AW-W){A[W-1]}}, A};
    assign b_x  = {{(AW-W){B[W-1]}}, B};

`ifdef ALU_DIV_EN
    assign div_q = (b_x == '0) ? '0 : a_x / b_x;
`else
    assign div_q = '0;
`endif

    always_comb begin
        arith_d = op == 2'd0 ? a_x + b_x :
                  op == 2'd1 ? a_x - b_x :
                  op == 2'd2 ? a_x * b_x : div_q;
        logic_d = op == 2'd0 ? A & B :
                  op == 2'd1 ? A | B :
                  op == 2'd2 ? ~(A & B) : ~(A | B);
        cmp_d   = op == 2'd1 ? (A == B ? W'(1) : '0) :
                  op == 2'd2 ? (A > B  ? W'(2) : '0) :
                  op == 2'd3 ? (A < B  ? W'(3) : '0) : '0;
        shift_d = op == 2'd0 ? $unsigned(A) >> 1 :
                  op == 2'd1 ? $unsigned(A) << 1 :
                  op == 2'd2 ? $unsigned(B) >> 1 : $unsigned(B) << 1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Arith_OUT  <= '0;
            Logic_Out  <= '0;
            CMP_Out    <= '0;
            Shift_Out  <= '0;
            Arith_Flag <= 1'b0;
            Logic_Flag <= 1'b0;
            CMP_Flag   <= 1'b0;
            Shift_Flag <= 1'b0;
        end else begin
            Arith_OUT  <= unit == 2'd0 ? arith_d : '0;
            Logic_Out  <= unit == 2'd1 ? logic_d : '0;
            CMP_Out    <= unit == 2'd2 ? cmp_d   : '0;
            Shift_Out  <= unit == 2'd3 ? shift_d : '0;
            Arith_Flag <= unit == 2'd0;
            Logic_Flag <= unit == 2'd1;
            CMP_Flag   <= unit == 2'd2;
            Shift_Flag <= unit == 2'd3;
        end
    end
endmodule

// File: tb/tb_signed_alu_top.sv
// tb_signed_alu_top: table-driven directed checks of signed_alu_top
module tb_signed_alu_top;
`ifdef ALU_DIV_EN
    localparam bit DIV = 1'b1;
`else
    localparam bit DIV = 1'b0;
`endif

    typedef struct {
        logic [3:0]  fun;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] arith;
        logic [15:0] lg;
        logic [15:0] cmp;
        logic [15:0] sh;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a, b;
    logic [3:0]  fun;
    logic [31:0] arith_out;
    logic [15:0] logic_out, cmp_out, shift_out;
    logic        arith_flag, logic_flag, cmp_flag, shift_flag;
    int          total = 0;
    int          bad = 0;
    vec_t        tbl [34];

    signed_alu_top dut (
        .clk(clk), .rst(rst), .A(a), .B(b), .ALU_FUN(fun),
        .Arith_OUT(arith_out), .Logic_Out(logic_out), .CMP_Out(cmp_out), .Shift_Out(shift_out),
        .Arith_Flag(arith_flag), .Logic_Flag(logic_flag), .CMP_Flag(cmp_flag), .Shift_Flag(shift_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] ea, input logic [15:0] el,
                           input logic [15:0] ec, input logic [15:0] es, input logic [3:0] ef);
        chk({tag, " arith"}, arith_out, ea);
        chk({tag, " logic"}, {16'h0, logic_out}, {16'h0, el});
        chk({tag, " cmp"}, {16'h0, cmp_out}, {16'h0, ec});
        chk({tag, " shift"}, {16'h0, shift_out}, {16'h0, es});
        chk({tag, " flags"}, {28'h0, arith_flag, logic_flag, cmp_flag, shift_flag}, {28'h0, ef});
    endtask

    function automatic vec_t mk(logic [3:0] f, logic [15:0] va, logic [15:0] vb,
                                logic [31:0] ea, logic [15:0] el, logic [15:0] ec, logic [15:0] es);
        vec_t v;
        v.fun = f; v.a = va; v.b = vb; v.arith = ea; v.lg = el; v.cmp = ec; v.sh = es;
        return v;
    endfunction

    initial begin
        tbl[0]  = mk(4'h4, 16'd5, 16'd6, 32'h0, 16'h0004, 16'h0, 16'h0);
        tbl[1]  = mk(4'h5, 16'd5, 16'd6, 32'h0, 16'h0007, 16'h0, 16'h0);
        tbl[2]  = mk(4'h6, 16'd5, 16'd6, 32'h0, 16'hFFFB, 16'h0, 16'h0);
        tbl[3]  = mk(4'h7, 16'd5, 16'd6, 32'h0, 16'hFFF8, 16'h0, 16'h0);
        tbl[4]  = mk(4'h8, 16'd5, 16'd6, 32'h0, 16'h0, 16'd0, 16'h0);
        tbl[5]  = mk(4'h9, 16'd5, 16'd6, 32'h0, 16'h0, 16'd0, 16'h0);
        tbl[6]  = mk(4'hA, 16'd5, 16'd6, 32'h0, 16'h0, 16'd0, 16'h0);
        tbl[7]  = mk(4'hB, 16'd5, 16'd6, 32'h0, 16'h0, 16'd3, 16'h0);
        tbl[8]  = mk(4'hA, 16'hFFFF, 16'hFFFE, 32'h0, 16'h0, 16'd2, 16'h0);
        tbl[9]  = mk(4'h9, 16'd7, 16'd7, 32'h0, 16'h0, 16'd1, 16'h0);
        tbl[10] = mk(4'hB, 16'hFFFD, 16'd2, 32'h0, 16'h0, 16'd3, 16'h0);
        tbl[11] = mk(4'hA, 16'hFFFD, 16'd2, 32'h0, 16'h0, 16'd0, 16'h0);
        tbl[12] = mk(4'hC, 16'd5, 16'd6, 32'h0, 16'h0, 16'h0, 16'd2);
        tbl[13] = mk(4'hD, 16'd5, 16'd6, 32'h0, 16'h0, 16'h0, 16'd10);
        tbl[14] = mk(4'hE, 16'd5, 16'd6, 32'h0, 16'h0, 16'h0, 16'd3);
        tbl[15] = mk(4'hF, 16'd5, 16'd6, 32'h0, 16'h0, 16'h0, 16'd12);
        tbl[16] = mk(4'hD, 16'h8001, 16'd6, 32'h0, 16'h0, 16'h0, 16'h0002);
        tbl[17] = mk(4'hC, 16'h8001, 16'd6, 32'h0, 16'h0, 16'h0, 16'h4000);
        tbl[18] = mk(4'h0, 16'hFFFC, 16'hFFFB, 32'hFFFFFFF7, 16'h0, 16'h0, 16'h0);
        tbl[19] = mk(4'h0, 16'h0004, 16'hFFFB, 32'hFFFFFFFF, 16'h0, 16'h0, 16'h0);
        tbl[20] = mk(4'h0, 16'hFFFC, 16'h0005, 32'h00000001, 16'h0, 16'h0, 16'h0);
        tbl[21] = mk(4'h0, 16'h0004, 16'h0005, 32'h00000009, 16'h0, 16'h0, 16'h0);
        tbl[22] = mk(4'h1, 16'hFFFC, 16'hFFFB, 32'h00000001, 16'h0, 16'h0, 16'h0);
        tbl[23] = mk(4'h1, 16'hFFFC, 16'h0005, 32'hFFFFFFF7, 16'h0, 16'h0, 16'h0);
        tbl[24] = mk(4'h1, 16'h0004, 16'hFFFB, 32'h00000009, 16'h0, 16'h0, 16'h0);
        tbl[25] = mk(4'h1, 16'h0004, 16'h0005, 32'hFFFFFFFF, 16'h0, 16'h0, 16'h0);
        tbl[26] = mk(4'h2, 16'hFFFC, 16'hFFFB, 32'h00000014, 16'h0, 16'h0, 16'h0);
        tbl[27] = mk(4'h2, 16'h0004, 16'hFFFB, 32'hFFFFFFEC, 16'h0, 16'h0, 16'h0);
        tbl[28] = mk(4'h2, 16'h8000, 16'h8000, 32'h40000000, 16'h0, 16'h0, 16'h0);
        tbl[29] = mk(4'h3, 16'hFFFC, 16'h0005, 32'h00000000, 16'h0, 16'h0, 16'h0);
        tbl[30] = mk(4'h3, 16'h0014, 16'hFFFD, DIV ? 32'hFFFFFFFA : 32'h0, 16'h0, 16'h0, 16'h0);
        tbl[31] = mk(4'h3, 16'h0007, 16'h0000, 32'h00000000, 16'h0, 16'h0, 16'h0);
        tbl[32] = mk(4'h3, 16'h8000, 16'hFFFF, DIV ? 32'h00008000 : 32'h0, 16'h0, 16'h0, 16'h0);
        tbl[33] = mk(4'h0, 16'h7FFF, 16'h7FFF, 32'h0000FFFE, 16'h0, 16'h0, 16'h0);

        // reset asserted before any clock edge must already clear everything
        rst = 1'b0; a = 16'hBEEF; b = 16'h1234; fun = 4'h2;
        #1;
        chk_all("reset_no_edge", 32'h0, 16'h0, 16'h0, 16'h0, 4'b0000);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 34; i++) begin
            a = tbl[i].a; b = tbl[i].b; fun = tbl[i].fun;
            @(posedge clk); #1;
            chk_all($sformatf("vec%0d", i), tbl[i].arith, tbl[i].lg, tbl[i].cmp, tbl[i].sh,
                    4'b1000 >> tbl[i].fun[3:2]);
            @(negedge clk);
        end

        // asynchronous reset mid-cycle clears outputs without a clock edge
        a = 16'd5; b = 16'd6; fun = 4'h5;
        @(posedge clk); #1;
        chk_all("pre_rst", 32'h0, 16'h0007, 16'h0, 16'h0, 4'b0100);
        #1 rst = 1'b0;
        #1;
        chk_all("async_rst", 32'h0, 16'h0, 16'h0, 16'h0, 4'b0000);
        // held through an edge while low
        @(posedge clk); #1;
        chk_all("rst_hold", 32'h0, 16'h0, 16'h0, 16'h0, 4'b0000);
        // release, change inputs; first edge gives a fresh result from current inputs
        @(negedge clk);
        rst = 1'b1; a = 16'hFFFC; b = 16'hFFFB; fun = 4'h2;
        @(posedge clk); #1;
        chk_all("post_rst", 32'h00000014, 16'h0, 16'h0, 16'h0, 4'b1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
